// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage with stall support and a one-entry pending-redirect buffer.
// Optional trap vector with EPC capture is enabled by defining PC_TRAP_EN.
module pc_unit #(
  parameter int              PC_W      = 32,
  parameter int              STEP      = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(32'h0000_0080)
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            pc_write_i,
  input  logic            jmp_take_i,
  input  logic [PC_W-1:0] jmp_target_i,
  input  logic            br_take_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            trap_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus_o,
  output logic            flush_o,
  output logic            pend_o,
  output logic [PC_W-1:0] epc_o
);

  localparam logic [PC_W-1:0] STEP_V     = PC_W'(STEP);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(STEP_V - PC_W'(1));

  typedef enum logic [1:0] {
    IDLE,
    PEND_JMP,
    PEND_BR
  } pend_state_t;

  pend_state_t     state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [PC_W-1:0] pend_buf, buf_nxt;
  logic            flush_q, flush_nxt;
  logic            trap_req;
  logic [PC_W-1:0] jmp_tgt, br_tgt;

  assign jmp_tgt = jmp_target_i & ALIGN_MASK;
  assign br_tgt  = br_target_i & ALIGN_MASK;

`ifdef PC_TRAP_EN
  logic [PC_W-1:0] epc_q;

  assign trap_req = trap_i;
  assign epc_o    = epc_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      epc_q <= '0;
    end else if (trap_req) begin
      epc_q <= pc_q;
    end
  end
`else
  logic unused_trap;

  assign unused_trap = trap_i;
  assign trap_req    = 1'b0;
  assign epc_o       = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc_q     <= RESET_VEC;
      pend_buf <= '0;
      flush_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      pend_buf <= buf_nxt;
      flush_q  <= flush_nxt;
    end
  end

  // A branch is older than any jump in flight, so a buffered branch is never displaced by a jump.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    buf_nxt   = pend_buf;
    flush_nxt = 1'b0;
    if (trap_req) begin
      pc_nxt    = TRAP_VEC & ALIGN_MASK;
      state_nxt = IDLE;
      flush_nxt = 1'b1;
    end else if (pc_write_i) begin
      state_nxt = IDLE;
      flush_nxt = 1'b1;
      if (br_take_i) begin
        pc_nxt = br_tgt;
      end else if (jmp_take_i) begin
        pc_nxt = jmp_tgt;
      end else if (state != IDLE) begin
        pc_nxt = pend_buf;
      end else begin
        pc_nxt    = pc_q + STEP_V;
        flush_nxt = 1'b0;
      end
    end else if (br_take_i) begin
      state_nxt = PEND_BR;
      buf_nxt   = br_tgt;
    end else if (jmp_take_i && state != PEND_BR) begin
      state_nxt = PEND_JMP;
      buf_nxt   = jmp_tgt;
    end
  end

  assign pc_o      = pc_q;
  assign pc_plus_o = pc_q + STEP_V;
  assign flush_o   = flush_q;
  assign pend_o    = (state != IDLE);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, 8-bit wrap instance, randomized run
// against a behavioural model, and an asynchronous mid-run reset.
module tb_pc_unit;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic [31:0] TRAP_T = 32'h80;

  typedef struct {
    logic        write;
    logic        jmp;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        trap;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic        exp_pend;
    logic [31:0] exp_epc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pc_write = 1'b0, jmp_take = 1'b0, br_take = 1'b0, trap = 1'b0;
  logic [31:0] jmp_target = '0, br_target = '0;
  logic [31:0] pc, pc_plus, epc;
  logic        flush, pend;

  logic       s_write = 1'b0, s_jmp = 1'b0;
  logic [7:0] s_jt = '0;
  logic [7:0] s_pc, s_plus, s_epc;
  logic       s_flush, s_pend;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: current PC, optional pending redirect (kind + target), flush, epc.
  logic [31:0] m_pc, m_buf, m_epc;
  bit          m_pend, m_pend_is_br, m_flush;

  always #5 clk = ~clk;

  pc_unit #(.PC_W(32), .STEP(4), .RESET_VEC(RST_PC), .TRAP_VEC(TRAP_T)) dut (
    .clk_i(clk), .rst_n(rst_n), .pc_write_i(pc_write),
    .jmp_take_i(jmp_take), .jmp_target_i(jmp_target),
    .br_take_i(br_take), .br_target_i(br_target), .trap_i(trap),
    .pc_o(pc), .pc_plus_o(pc_plus), .flush_o(flush), .pend_o(pend), .epc_o(epc)
  );

  pc_unit #(.PC_W(8), .STEP(4), .RESET_VEC(8'h00), .TRAP_VEC(8'h80)) dut_small (
    .clk_i(clk), .rst_n(rst_n), .pc_write_i(s_write),
    .jmp_take_i(s_jmp), .jmp_target_i(s_jt),
    .br_take_i(1'b0), .br_target_i(8'h00), .trap_i(1'b0),
    .pc_o(s_pc), .pc_plus_o(s_plus), .flush_o(s_flush), .pend_o(s_pend), .epc_o(s_epc)
  );

  function automatic logic [31:0] align4(input logic [31:0] x);
    return x - (x % 32'd4);
  endfunction

  function automatic vec_t mk(input logic w, input logic j, input logic [31:0] jt,
                              input logic b, input logic [31:0] bt, input logic t,
                              input logic [31:0] epc_v, input logic f, input logic p,
                              input logic [31:0] e);
    vec_t v;
    v.write = w; v.jmp = j; v.jt = jt; v.br = b; v.bt = bt; v.trap = t;
    v.exp_pc = epc_v; v.exp_flush = f; v.exp_pend = p; v.exp_epc = e;
    return v;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_buf = '0; m_epc = '0;
    m_pend = 0; m_pend_is_br = 0; m_flush = 0;
  endtask

  task automatic model_update(input vec_t v);
    bit trap_on;
`ifdef PC_TRAP_EN
    trap_on = v.trap;
`else
    trap_on = 0;
`endif
    if (trap_on) begin
      m_epc = m_pc; m_pc = align4(TRAP_T); m_pend = 0; m_flush = 1;
    end else if (v.write) begin
      m_flush = v.br || v.jmp || m_pend;
      if (v.br) m_pc = align4(v.bt);
      else if (v.jmp) m_pc = align4(v.jt);
      else if (m_pend) m_pc = m_buf;
      else m_pc = m_pc + 32'd4;
      m_pend = 0;
    end else begin
      m_flush = 0;
      if (v.br) begin
        m_pend = 1; m_pend_is_br = 1; m_buf = align4(v.bt);
      end else if (v.jmp && !(m_pend && m_pend_is_br)) begin
        m_pend = 1; m_pend_is_br = 0; m_buf = align4(v.jt);
      end
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    pc_write = v.write; jmp_take = v.jmp; jmp_target = v.jt;
    br_take = v.br; br_target = v.bt; trap = v.trap;
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, " pc"}, pc, m_pc);
    check_output({tag, " pc_plus"}, pc_plus, m_pc + 32'd4);
    check_output({tag, " flush"}, {31'b0, flush}, {31'b0, m_flush});
    check_output({tag, " pend"}, {31'b0, pend}, {31'b0, m_pend});
    check_output({tag, " epc"}, epc, m_epc);
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = mk(0, 0, '0, 0, '0, 0, '0, 0, 0, '0);

    // Reset is asserted away from any clock edge; outputs must follow immediately.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_output("reset pc", pc, RST_PC);
    check_output("reset flush", {31'b0, flush}, 32'd0);
    check_output("reset pend", {31'b0, pend}, 32'd0);
    check_output("reset epc", epc, 32'd0);
    check_output("reset pc_plus", pc_plus, 32'h104);
    check_output("small reset pc", {24'b0, s_pc}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit instance wrap: jump to FC, then sequential step to 00.
    s_write = 1'b1; s_jmp = 1'b1; s_jt = 8'hFE;
    apply_stimulus(idle);
    check_output("small jump pc", {24'b0, s_pc}, 32'hFC);
    check_output("small jump flush", {31'b0, s_flush}, 32'd1);
    check_output("small epc", {24'b0, s_epc}, 32'd0);
    s_jmp = 1'b0;
    apply_stimulus(idle);
    check_output("small wrap pc", {24'b0, s_pc}, 32'h00);
    check_output("small wrap pc_plus", {24'b0, s_plus}, 32'h04);
    check_output("small wrap flush", {31'b0, s_flush}, 32'd0);
    check_output("small pend", {31'b0, s_pend}, 32'd0);
    check_model("stall hold");

    //           w  j  jt            b  bt            t  pc            f  p  epc
    tbl.push_back(mk(1, 0, '0,          0, '0,          0, 32'h104,     0, 0, '0));
    tbl.push_back(mk(1, 0, '0,          0, '0,          0, 32'h108,     0, 0, '0));
    tbl.push_back(mk(1, 0, '0,          0, '0,          0, 32'h10C,     0, 0, '0));
    tbl.push_back(mk(1, 1, 32'h200,     0, '0,          0, 32'h200,     1, 0, '0));
    tbl.push_back(mk(0, 0, '0,          1, 32'h403,     0, 32'h200,     0, 1, '0));
    tbl.push_back(mk(0, 0, '0,          0, '0,          0, 32'h200,     0, 1, '0));
    tbl.push_back(mk(1, 0, '0,          0, '0,          0, 32'h400,     1, 0, '0));
    tbl.push_back(mk(1, 0, '0,          0, '0,          0, 32'h404,     0, 0, '0));
    tbl.push_back(mk(0, 1, 32'h300,     0, '0,          0, 32'h404,     0, 1, '0));
    tbl.push_back(mk(0, 0, '0,          1, 32'h500,     0, 32'h404,     0, 1, '0));
    tbl.push_back(mk(0, 1, 32'h600,     0, '0,          0, 32'h404,     0, 1, '0));
    tbl.push_back(mk(1, 0, '0,          0, '0,          0, 32'h500,     1, 0, '0));
    tbl.push_back(mk(1, 1, 32'h900,     1, 32'h800,     0, 32'h800,     1, 0, '0));
    tbl.push_back(mk(0, 1, 32'h300,     0, '0,          0, 32'h800,     0, 1, '0));
    tbl.push_back(mk(1, 0, '0,          1, 32'h90B,     0, 32'h908,     1, 0, '0));
    tbl.push_back(mk(1, 0, '0,          0, '0,          0, 32'h90C,     0, 0, '0));
    tbl.push_back(mk(1, 1, 32'h241,     0, '0,          0, 32'h240,     1, 0, '0));
    tbl.push_back(mk(0, 0, '0,          1, 32'h700,     0, 32'h240,     0, 1, '0));
`ifdef PC_TRAP_EN
    tbl.push_back(mk(0, 0, '0,          0, '0,          1, 32'h080,     1, 0, 32'h240));
    tbl.push_back(mk(1, 0, '0,          0, '0,          0, 32'h084,     0, 0, 32'h240));
`else
    tbl.push_back(mk(0, 0, '0,          0, '0,          1, 32'h240,     0, 1, '0));
    tbl.push_back(mk(1, 0, '0,          0, '0,          0, 32'h700,     1, 0, '0));
`endif

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i]);
      check_output($sformatf("vec%0d pc", i), pc, tbl[i].exp_pc);
      check_output($sformatf("vec%0d pc_plus", i), pc_plus, tbl[i].exp_pc + 32'd4);
      check_output($sformatf("vec%0d flush", i), {31'b0, flush}, {31'b0, tbl[i].exp_flush});
      check_output($sformatf("vec%0d pend", i), {31'b0, pend}, {31'b0, tbl[i].exp_pend});
      check_output($sformatf("vec%0d epc", i), epc, tbl[i].exp_epc);
    end

    // Randomized traffic with occasional top-of-range jumps to exercise 32-bit wrap.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = idle;
      v.write = ($urandom_range(0, 9) < 6);
      v.jmp   = ($urandom_range(0, 3) == 0);
      v.br    = ($urandom_range(0, 4) == 0);
      v.trap  = ($urandom_range(0, 19) == 0);
      v.jt    = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFD : $urandom;
      v.bt    = $urandom;
      apply_stimulus(v);
      check_model($sformatf("rand%0d", n));
    end

    // Asynchronous reset in the middle of a cycle, then normal restart.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("midrun reset");
    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t v;
      v = idle;
      v.write = 1'b1;
      apply_stimulus(v);
      check_model("after reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined core's IF stage; it replaces the single-register PC with stall support. Each cycle it selects the next fetch address from reset vector, sequential increment, ID-stage jump, EX-stage branch, a buffered redirect, or (optionally) a trap vector. A redirect that arrives while the PC is stalled is held in a one-entry pending buffer and applied on release, so redirects are never lost under hazard stalls.

## Interface
- PC_W, 32: PC width in bits (≥ 8).
- STEP, 4: sequential increment in bytes; power of two, ≥ 1.
- RESET_VEC, 0: PC value after reset.
- TRAP_VEC, 32'h0000_0080: trap target (used only with PC_TRAP_EN).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_write_i  in  1  1 = PC may update; 0 = stall (hold PC).
- jmp_take_i  in  1  jump resolved in ID this cycle.
- jmp_target_i  in  PC_W  jump target.
- br_take_i  in  1  taken branch resolved in EX this cycle.
- br_target_i  in  PC_W  branch target.
- trap_i  in  1  trap request (PC_TRAP_EN only; ignored otherwise).
- pc_o  out  PC_W  current fetch address (registered).
- pc_plus_o  out  PC_W  pc_o + STEP, modulo 2^PC_W (combinational from pc_o).
- flush_o  out  1  registered; 1 for the cycle after a redirect is written into pc_o.
- pend_o  out  1  registered; pending-redirect buffer occupied.
- epc_o  out  PC_W  PC of the trapped fetch (PC_TRAP_EN only; else constant 0).

## Operation
- Targets are aligned: low log2(STEP) bits of every target forced to 0 before use.
- Pending FSM states: IDLE, PEND_JMP, PEND_BR; buffer holds one PC_W target.
- Next-PC priority when pc_write_i=1: trap > br_take_i > jmp_take_i > pending target > pc_o+STEP.
- Update with pc_write_i=1: pc_o ← selected value; pending state → IDLE; flush_o next cycle = 1 iff selection was trap, branch, jump or pending.
- Stall (pc_write_i=0, no trap): pc_o holds; flush_o=0.
  - br_take_i: state → PEND_BR, buffer ← br_target_i (overwrites any pending).
  - jmp_take_i without br_take_i: IDLE → PEND_JMP, buffer ← jmp_target_i; PEND_JMP overwritten by new jump; PEND_BR retained (older branch wins).
  - Neither: state and buffer unchanged.
- Trap (PC_TRAP_EN): applies regardless of pc_write_i; pc_o ← TRAP_VEC aligned; epc_o ← current pc_o; pending → IDLE; flush_o=1 next cycle.
- Sequential wrap-around: pc_o = 2^PC_W − STEP increments to 0; no flag.
- pend_o = (state ≠ IDLE).

## Timing
- Reset (async, immediate): pc_o=RESET_VEC, state IDLE, buffer 0, flush_o=0, pend_o=0, epc_o=0. Deassertion synchronous to clk_i in the system; first update on the first rising edge after release.
- Redirect latency: target visible on pc_o one cycle after the request edge (pc_write_i=1), or one cycle after the first edge with pc_write_i=1 when buffered.
- Simultaneous release and new redirect: new branch/jump beats pending target; pending cleared.
- Simultaneous branch and jump: branch taken, jump discarded (it lies on the wrong path).
- No combinational path from inputs to any output except pc_plus_o (from pc_o only).

## Configuration
- PC_TRAP_EN defined: trap_i honoured at top priority, epc_o register implemented.
- Undefined: trap_i ignored, no epc register, epc_o tied to 0; all other behaviour identical.

## Test plan
- Reset with RESET_VEC=32'h100, STEP=4, pc_write_i=1 for 3 cycles → pc_o 100, 104, 108, 10C; flush_o=0, pend_o=0.
- pc_o=200, pc_write_i=0 for 2 cycles with br_take_i=1, br_target_i=32'h403 in the first → pc_o holds 200, pend_o=1; release → pc_o=400, flush_o=1 one cycle, pend_o=0.
- Stalled, jmp 300 buffered, then br 500 in a later stalled cycle, then jmp 600 → buffer stays 500 (PEND_BR); release → pc_o=500.
- br_take_i=1 (800) and jmp_take_i=1 (900) same cycle, pc_write_i=1 → pc_o=800.
- PC_W=8, STEP=4, pc_o=8'hFC, pc_write_i=1 → pc_o=00, pc_plus_o=04.
- PC_TRAP_EN: pc_o=240, pc_write_i=0, pending branch held, trap_i=1 → pc_o=80, epc_o=240, pend_o=0, flush_o=1; without the macro, pc_o holds 240.
